// File: rtl/arbitro_rr_param_pkg.sv
// Shared types and helpers for the parametrised round-robin arbiter.
package arbitro_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int CNT_W  = 16;
  localparam int MAX_CH = 16;
  localparam int MAX_DW = 4;

  // Returns {found, idx}: first set bit of req at or after ptr, wrapping at n.
  function automatic logic [MAX_DW:0] rr_pick(input logic [MAX_CH-1:0] req,
                                               input logic [MAX_DW-1:0] ptr,
                                               input int n);
    logic [MAX_DW:0] res;
    logic [MAX_DW:0] idx;
    res = '0;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (MAX_DW+1)'(k);
      if (idx >= (MAX_DW+1)'(n)) idx = idx - (MAX_DW+1)'(n);
      if (k < n && req[idx[MAX_DW-1:0]]) res = {1'b1, idx[MAX_DW-1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/arbitro_rr_param_rr_selector.sv
// Combinational winner selection: eligible vector plus start pointer to
// one-hot grant and index (fixed priority ignores the pointer).
module rr_selector
  import arbitro_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int DW      = 2,
  parameter int RR_MODE = 1
) (
  input  logic [N_CH-1:0] elig,
  input  logic [DW-1:0]   ptr,
  output logic            found,
  output logic [DW-1:0]   idx,
  output logic [N_CH-1:0] grant
);

  logic [MAX_CH-1:0] req;
  logic [MAX_DW-1:0] start;
  logic [MAX_DW:0]   pick;

  always_comb begin
    req             = '0;
    req[N_CH-1:0]   = elig;
    start           = '0;
    if (RR_MODE != 0) start[DW-1:0] = ptr;
    pick  = rr_pick(req, start, N_CH);
    found = pick[MAX_DW];
    idx   = DW'(pick[MAX_DW-1:0]);
    grant = '0;
    if (found) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/arbitro_rr_param.sv
// N_CH-channel FIFO-to-FIFO arbiter: pop one cycle after grant, push one after.
// Optional per-channel grant and stall counters when ARB_GRANT_COUNT_EN is defined.
module arbitro_rr_param
  import arbitro_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int DW           = $clog2(N_CH),
  parameter int RR_MODE      = 1,
  parameter int GLOBAL_PAUSE = 1
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               active,
  input  logic [N_CH-1:0]    empty,
  input  logic [N_CH*DW-1:0] head_dest,
  input  logic [N_CH-1:0]    almost_full,
  output logic [N_CH-1:0]    pop,
  output logic [N_CH-1:0]    push,
  output logic [DW-1:0]      dest_sel,
  output logic [DW-1:0]      src_sel,
  output logic [N_CH-1:0]    empties,
  output logic               idle
`ifdef ARB_GRANT_COUNT_EN
  ,
  output logic [N_CH*CNT_W-1:0] grant_cnt,
  output logic [CNT_W-1:0]      stall_cnt
`endif
);

  logic [N_CH-1:0] elig;
  logic [DW-1:0]   d;
  logic            found;
  logic [DW-1:0]   win_idx;
  logic [N_CH-1:0] grant;
  logic [DW-1:0]   ptr;
  logic            vld_p1;
  logic [DW-1:0]   src_p1;
  logic [DW-1:0]   dest_p1;
  arb_state_t      state, state_nxt;

  // Out-of-range destinations (non power-of-two N_CH) are never eligible.
  always_comb begin
    elig = '0;
    d    = '0;
    for (int i = 0; i < N_CH; i++) begin
      d = head_dest[i*DW +: DW];
      if (!empty[i] && active && (int'(d) < N_CH) && !almost_full[d] &&
          !(GLOBAL_PAUSE != 0 && |almost_full))
        elig[i] = 1'b1;
    end
  end

  rr_selector #(
    .N_CH    (N_CH),
    .DW      (DW),
    .RR_MODE (RR_MODE)
  ) u_sel (
    .elig  (elig),
    .ptr   (ptr),
    .found (found),
    .idx   (win_idx),
    .grant (grant)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pop      <= '0;
      vld_p1   <= 1'b0;
      src_p1   <= '0;
      dest_p1  <= '0;
      push     <= '0;
      dest_sel <= '0;
      src_sel  <= '0;
      empties  <= '1;
      ptr      <= '0;
      state    <= IDLE;
    end else begin
      // stage 1: pop the winner, capture the destination its head word named
      pop     <= grant;
      vld_p1  <= found;
      src_p1  <= win_idx;
      dest_p1 <= head_dest[win_idx*DW +: DW];
      // stage 2: push lands once the FIFO read data is available
      push     <= {{(N_CH-1){1'b0}}, vld_p1} << dest_p1;
      dest_sel <= vld_p1 ? dest_p1 : '0;
      src_sel  <= vld_p1 ? src_p1 : '0;
      empties  <= empty;
      if (found) ptr <= (win_idx == DW'(N_CH - 1)) ? '0 : win_idx + 1'b1;
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = XFER;
      XFER:    if (!found) state_nxt = vld_p1 ? DRAIN : IDLE;
      DRAIN:   state_nxt = found ? XFER : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign idle = (state == IDLE) && (pop == '0) && (push == '0);

`ifdef ARB_GRANT_COUNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++)
        if (pop[i]) grant_cnt[i*CNT_W +: CNT_W] <= sat_inc(grant_cnt[i*CNT_W +: CNT_W]);
      if (|(~empty) && !found) stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_arbitro_rr_param.sv
// Bench: four arbiter configurations share one random stimulus stream and are
// compared every cycle against a per-configuration reference model.
module tb_arbitro_rr_param;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       active = 1'b0;
  logic [3:0] empty = 4'hF;
  logic [3:0] af = 4'h0;
  logic [7:0] hd = 8'h00;

  always #5 clk = ~clk;

  // instances 0..2: N_CH=4 (RR, fixed priority, RR with global pause); 3: N_CH=3 RR
  logic [3:0] o_pop[3], o_push[3], o_emp[3];
  logic [1:0] o_ds[3], o_ss[3];
  logic       o_idle[3];
  logic [2:0] pop3, push3, emp3;
  logic [1:0] ds3, ss3;
  logic       idle3;
`ifdef ARB_GRANT_COUNT_EN
  logic [63:0] o_gc[3];
  logic [15:0] o_sc[3];
  logic [47:0] gc3;
  logic [15:0] sc3;
`endif

  arbitro_rr_param #(.N_CH(4), .RR_MODE(1), .GLOBAL_PAUSE(0)) dut_rr (
    .clk(clk), .reset_L(reset_L), .active(active), .empty(empty), .head_dest(hd),
    .almost_full(af), .pop(o_pop[0]), .push(o_push[0]), .dest_sel(o_ds[0]),
    .src_sel(o_ss[0]), .empties(o_emp[0]), .idle(o_idle[0])
`ifdef ARB_GRANT_COUNT_EN
    , .grant_cnt(o_gc[0]), .stall_cnt(o_sc[0])
`endif
  );

  arbitro_rr_param #(.N_CH(4), .RR_MODE(0), .GLOBAL_PAUSE(0)) dut_fp (
    .clk(clk), .reset_L(reset_L), .active(active), .empty(empty), .head_dest(hd),
    .almost_full(af), .pop(o_pop[1]), .push(o_push[1]), .dest_sel(o_ds[1]),
    .src_sel(o_ss[1]), .empties(o_emp[1]), .idle(o_idle[1])
`ifdef ARB_GRANT_COUNT_EN
    , .grant_cnt(o_gc[1]), .stall_cnt(o_sc[1])
`endif
  );

  arbitro_rr_param #(.N_CH(4), .RR_MODE(1), .GLOBAL_PAUSE(1)) dut_gp (
    .clk(clk), .reset_L(reset_L), .active(active), .empty(empty), .head_dest(hd),
    .almost_full(af), .pop(o_pop[2]), .push(o_push[2]), .dest_sel(o_ds[2]),
    .src_sel(o_ss[2]), .empties(o_emp[2]), .idle(o_idle[2])
`ifdef ARB_GRANT_COUNT_EN
    , .grant_cnt(o_gc[2]), .stall_cnt(o_sc[2])
`endif
  );

  arbitro_rr_param #(.N_CH(3), .RR_MODE(1), .GLOBAL_PAUSE(0)) dut_n3 (
    .clk(clk), .reset_L(reset_L), .active(active), .empty(empty[2:0]),
    .head_dest(hd[5:0]), .almost_full(af[2:0]), .pop(pop3), .push(push3),
    .dest_sel(ds3), .src_sel(ss3), .empties(emp3), .idle(idle3)
`ifdef ARB_GRANT_COUNT_EN
    , .grant_cnt(gc3), .stall_cnt(sc3)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_ptr[4], m_pop[4], m_pdst[4], m_push[4], m_psrc[4];
  int         gc[4][4], sc[4];
  logic [3:0] m_emp;

  function automatic int nch(input int k);
    return (k == 3) ? 3 : 4;
  endfunction

  function automatic logic [3:0] mask(input int k);
    return (k == 3) ? 4'h7 : 4'hF;
  endfunction

  function automatic int pick(input int k);
    int n, c, d, best;
    bit rr, gp;
    n    = nch(k);
    rr   = (k != 1);
    gp   = (k == 2);
    best = -1;
    for (int off = 0; off < n; off++) begin
      c = rr ? (m_ptr[k] + off) % n : off;
      d = int'(hd[2*c +: 2]);
      if (best < 0 && !empty[c] && active && d < n && !af[d] &&
          !(gp && (af & mask(k)) != 4'h0))
        best = c;
    end
    return best;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_ptr[k] = 0; m_pop[k] = -1; m_push[k] = -1; m_pdst[k] = 0; m_psrc[k] = 0;
      sc[k] = 0;
      for (int c = 0; c < 4; c++) gc[k][c] = 0;
    end
    m_emp = 4'hF;
  endtask

  task automatic fetch(input int k, output logic [3:0] p, output logic [3:0] u,
                       output logic [3:0] e, output logic [1:0] ds,
                       output logic [1:0] ss, output logic id);
    if (k < 3) begin
      p = o_pop[k]; u = o_push[k]; e = o_emp[k]; ds = o_ds[k]; ss = o_ss[k]; id = o_idle[k];
    end else begin
      p = {1'b0, pop3}; u = {1'b0, push3}; e = {1'b0, emp3}; ds = ds3; ss = ss3; id = idle3;
    end
  endtask

`ifdef ARB_GRANT_COUNT_EN
  function automatic logic [15:0] gcv(input int k, input int c);
    if (k < 3) return o_gc[k][c*16 +: 16];
    return gc3[c*16 +: 16];
  endfunction

  function automatic logic [15:0] scv(input int k);
    return (k < 3) ? o_sc[k] : sc3;
  endfunction
`endif

  task automatic check_all();
    logic [3:0] p, u, e;
    logic [1:0] ds, ss;
    logic       id;
    for (int k = 0; k < 4; k++) begin
      fetch(k, p, u, e, ds, ss, id);
      chk($sformatf("pop%0d", k), 32'(p), (m_pop[k] >= 0) ? (32'd1 << m_pop[k]) : 32'd0);
      chk($sformatf("push%0d", k), 32'(u), (m_push[k] >= 0) ? (32'd1 << m_push[k]) : 32'd0);
      if (m_push[k] >= 0) begin
        chk($sformatf("dest_sel%0d", k), 32'(ds), 32'(m_push[k]));
        chk($sformatf("src_sel%0d", k), 32'(ss), 32'(m_psrc[k]));
      end
      chk($sformatf("empties%0d", k), 32'(e), 32'(m_emp & mask(k)));
      chk($sformatf("idle%0d", k), 32'(id), 32'(m_pop[k] < 0 && m_push[k] < 0));
`ifdef ARB_GRANT_COUNT_EN
      for (int c = 0; c < nch(k); c++)
        chk($sformatf("grant_cnt%0d_%0d", k, c), 32'(gcv(k, c)), 32'(gc[k][c]));
      chk($sformatf("stall_cnt%0d", k), 32'(scv(k)), 32'(sc[k]));
`endif
    end
  endtask

  // One clock: model decides from the current inputs, edge, then compare.
  task automatic step();
    int w[4], wd[4];
    bit st[4];
    for (int k = 0; k < 4; k++) begin
      w[k]  = pick(k);
      wd[k] = (w[k] >= 0) ? int'(hd[2*w[k] +: 2]) : 0;
      st[k] = (((~empty) & mask(k)) != 4'h0) && (w[k] < 0);
    end
    @(posedge clk);
    if (!reset_L) model_reset();
    else begin
      for (int k = 0; k < 4; k++) begin
        if (m_pop[k] >= 0 && gc[k][m_pop[k]] < 65535) gc[k][m_pop[k]]++;
        if (st[k] && sc[k] < 65535) sc[k]++;
        m_push[k] = (m_pop[k] >= 0) ? m_pdst[k] : -1;
        m_psrc[k] = m_pop[k];
        m_pop[k]  = w[k];
        if (w[k] >= 0) begin
          m_pdst[k] = wd[k];
          m_ptr[k]  = (w[k] + 1) % nch(k);
        end
      end
      m_emp = empty;
    end
    #1;
    check_all();
  endtask

  // Asynchronous reset between edges: everything must clear without a clock.
  task automatic async_rst();
    #2 reset_L = 1'b0;
    #1;
    model_reset();
    check_all();
    step();
    reset_L = 1'b1;
  endtask

  task automatic randomize_inputs();
    empty  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
    hd     = 8'($urandom);
    af     = 4'($urandom) & 4'($urandom) & 4'($urandom);
    active = ($urandom_range(0, 9) != 0);
  endtask

  initial begin
    model_reset();
    // reset held with random inputs, then released with everything empty
    repeat (3) begin
      randomize_inputs();
      step();
    end
    empty = 4'hF; active = 1'b1; af = 4'h0; hd = 8'hE4;
    reset_L = 1'b1;
    repeat (3) step();

    // fairness: every channel non-empty, channel i heading to output i
    empty = 4'h0; hd = 8'hE4;
    repeat (9) step();

    // back-pressure: ch1 heads to blocked output 2, then output 1 also blocked
    hd = 8'hD8; af = 4'b0100;
    repeat (8) step();
    af = 4'b0110;
    repeat (6) step();
    af = 4'h0;
    repeat (4) step();

    // active drops right after a pop
    hd = 8'hE4; active = 1'b1;
    step();
    active = 1'b0;
    repeat (4) step();

    // fixed priority: ch0 and ch3 busy, then ch0 runs dry
    active = 1'b1; empty = 4'b0110;
    repeat (6) step();
    empty = 4'b0111;
    repeat (4) step();

    // reset between a pop and its push
    empty = 4'h0;
    repeat (2) step();
    async_rst();
    repeat (3) step();

    repeat (500) begin
      randomize_inputs();
      if ($urandom_range(0, 99) == 0) async_rst();
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arbitro_rr_param.md
Name: arbitro_rr_param

Overview:
- Parametrised successor of the 4-channel orange/purple arbiter.
- Arbitrates N_CH input FIFOs into N_CH output FIFOs. Each input FIFO's head word carries a destination index.
- Grants one transfer per cycle using round-robin or fixed priority. Asserts the pop to the source, then the push to the destination one cycle later.
- Respects output almost_full back-pressure. Sits between the input VC FIFOs and the output FIFOs, gated by the top-level FSM's active state.

Parameters:
- N_CH, 4, number of input and output channels (2..16).
- DW, $clog2(N_CH), width of each destination index.
- RR_MODE, 1, 1 = round-robin among eligible channels; 0 = fixed priority, lowest index wins.
- GLOBAL_PAUSE, 1, 1 = any almost_full blocks all grants (legacy behaviour); 0 = only a blocked destination stalls.

Ports:
- clk  in  1  system clock, rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- active  in  1  top FSM in ACTIVE state; grants allowed only when 1.
- empty  in  N_CH  input FIFO empty flags.
- head_dest  in  N_CH*DW  destination index of each input FIFO's head word; channel i occupies bits [i*DW +: DW].
- almost_full  in  N_CH  output FIFO almost_full flags.
- pop  out  N_CH  one-hot registered pop to the input FIFOs.
- push  out  N_CH  one-hot registered push to the output FIFOs.
- dest_sel  out  DW  index of the output pushed this cycle; valid while push != 0.
- src_sel  out  DW  index of the input that supplied the pushed word.
- empties  out  N_CH  registered copy of empty, for monitoring.
- idle  out  1  1 when no grant is pending and nothing is in flight.

Behaviour:
- Reset (reset_L = 0, asynchronous):
  - pop = 0, push = 0, dest_sel = 0, src_sel = 0, empties = all ones, idle = 1.
  - Round-robin pointer = 0; FSM state = IDLE.
- Eligibility (combinational), channel i is eligible when all of the following hold:
  - empty[i] = 0;
  - active = 1;
  - almost_full[head_dest[i]] = 0;
  - if GLOBAL_PAUSE = 1, additionally |almost_full = 0.
- Selection:
  - RR_MODE = 1: search from pointer ptr upward with wrap-around. The first eligible channel wins. On each grant, ptr <= winner + 1 mod N_CH. ptr holds when there is no grant.
  - RR_MODE = 0: the lowest eligible index wins; ptr is unused.
- Timing:
  - Cycle t: grant decided → pop[g] = 1 at cycle t+1 (registered).
  - Cycle t+1: captured destination d → push[d] = 1, dest_sel = d, src_sel = g at cycle t+2. This matches the FIFO one-cycle read latency.
  - Back-to-back grants are allowed, so one pop and one push can occur every cycle.
- In-flight hazard: a channel popped at t+1 is excluded at t+1 if its FIFO went empty. The eligibility evaluated at t+1 uses the updated empty flag, which the FIFO provides combinationally.
- FSM states and transitions:
  - IDLE: no grant pending.
  - IDLE → XFER on a grant.
  - XFER stays in XFER while grants continue.
  - XFER → DRAIN when there is no grant but a push is still owed.
  - DRAIN → IDLE after the push.
  - idle = 1 only in IDLE with pop = 0 and push = 0.
- Boundary conditions:
  - active falls mid-stream: no new grants. An owed push still completes.
  - almost_full rises in the same cycle as a grant decision: no grant to that destination (the check is combinational).
  - Out-of-range head_dest (≥ N_CH, non-power-of-two N_CH): the channel is treated as ineligible.
  - All channels empty: outputs hold 0 and ptr holds.
  - reset_L asserted mid-transfer: the owed push is dropped and all outputs clear immediately.
- Widths: ptr is DW bits. Wrap uses compare-to-(N_CH-1), not natural overflow.

Optional Feature:
- Macro: ARB_GRANT_COUNT_EN.
- With the macro defined, the block adds these outputs:
  - grant_cnt, N_CH*16 bits: per-channel saturating counters of pops, cleared by reset_L.
  - stall_cnt, 16 bits: counts cycles with ≥1 non-empty input but no grant (back-pressure or inactive).
- Counters saturate at 16'hFFFF.
- Without the macro, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Package arbitro_pkg holds:
  - FSM state enum (IDLE = 2'd0, XFER = 2'd1, DRAIN = 2'd2);
  - counter width constant CNT_W = 16;
  - a function rr_pick(req, ptr) returning {found, idx}.
- Sub-module rr_selector (N_CH, RR_MODE): combinational eligible vector + ptr → one-hot grant and index.
- The top module keeps the pop/push pipeline registers, the FSM and the ptr register.

Test Plan (N_CH = 4, RR_MODE = 1, GLOBAL_PAUSE = 0 unless stated):
1. Reset: hold reset_L = 0 with random inputs → pop = 0, push = 0, empties = 4'hF, idle = 1. Release → no activity while empty = 4'hF.
2. Round-robin fairness: all four FIFOs non-empty with dest = {3,2,1,0}, active = 1 → pop sequence 0,1,2,3,0… on consecutive cycles; push one cycle later on dest 0,1,2,3 with matching src_sel.
3. Back-pressure: almost_full = 4'b0100 and ch1 head_dest = 2 → ch1 is skipped, pop order 0,2,3,0; raise almost_full[1] → ch1 skipped. Repeat with GLOBAL_PAUSE = 1 → zero pops until almost_full = 0.
4. active drop: deassert active in the cycle after a pop → exactly one trailing push, then idle = 1 one cycle later.
5. Fixed priority (RR_MODE = 0): ch0 and ch3 continuously non-empty → only ch0 popped. Empty ch0 → ch3 popped on the next cycle.
6. Async reset mid-transfer: assert reset_L between pop and push → push never appears and outputs clear immediately. With ARB_GRANT_COUNT_EN, grant_cnt = 0 afterwards and stall_cnt increments during the test 3 stalls.
